// File: rtl/npu_noc_pkg.sv
// Shared definitions for the mesh router: port indices, route result type and XY routing.
package npu_noc_pkg;

  localparam int N_PORTS = 5;
  localparam int PORT_W  = 3;

  localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] P_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] P_EAST  = 3'd2;
  localparam logic [PORT_W-1:0] P_SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] P_WEST  = 3'd4;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic              drop;
  } route_t;

  function automatic logic [PORT_W-1:0] rr_next(input logic [PORT_W-1:0] grantee);
    return (grantee == P_WEST) ? P_LOCAL : grantee + 3'd1;
  endfunction

  // X first, then Y; a hop off the mesh edge or an out-of-mesh destination is dropped.
  function automatic route_t xy_route(input int unsigned dst_x, input int unsigned dst_y,
                                      input int unsigned rtr_x, input int unsigned rtr_y,
                                      input int unsigned mesh_x, input int unsigned mesh_y);
    route_t r;
    r.drop = 1'b0;
    if (dst_x > rtr_x)      r.port = P_EAST;
    else if (dst_x < rtr_x) r.port = P_WEST;
    else if (dst_y > rtr_y) r.port = P_NORTH;
    else if (dst_y < rtr_y) r.port = P_SOUTH;
    else                    r.port = P_LOCAL;
    if (dst_x >= mesh_x || dst_y >= mesh_y)                 r.drop = 1'b1;
    if (r.port == P_EAST  && rtr_x == mesh_x - 1)           r.drop = 1'b1;
    if (r.port == P_WEST  && rtr_x == 0)                    r.drop = 1'b1;
    if (r.port == P_NORTH && rtr_y == mesh_y - 1)           r.drop = 1'b1;
    if (r.port == P_SOUTH && rtr_y == 0)                    r.drop = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/noc_input_fifo.sv
// Per-input flit FIFO; head is the oldest entry, push and pop may happen in the same cycle.
module noc_input_fifo #(
  parameter int FLIT_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: combinational next-state uses blocking '='; only the flop processes use '<='.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; emptiness is defined by count_q alone, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/noc_mesh_router.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin arbiter and output register.
module noc_mesh_router
  import npu_noc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MESH_X     = 8,
  parameter int MESH_Y     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int XW        = $clog2(MESH_X),
  localparam int YW        = $clog2(MESH_Y),
  localparam int FLIT_W    = XW + YW + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [XW-1:0]             router_x,
  input  logic [YW-1:0]             router_y,
  input  logic [N_PORTS*FLIT_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_valid,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [N_PORTS*FLIT_W-1:0] out_data,
  output logic [N_PORTS-1:0]        out_valid,
  input  logic [N_PORTS-1:0]        out_ready,
  output logic [15:0]               drop_cnt
);

  logic [FLIT_W-1:0]                head [N_PORTS];
  logic [N_PORTS-1:0]               full, empty, pop, drop;
  logic [N_PORTS-1:0][N_PORTS-1:0]  req;      // req[output][input]
  logic [N_PORTS-1:0][N_PORTS-1:0]  gnt_eff;  // grants that actually load an output register
  route_t                           rt;
  logic [15:0]                      drop_cnt_q, drop_cnt_d;
  logic [18:0]                      drop_sum;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_in
    noc_input_fifo #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[p]),
      .push_data (in_data[p*FLIT_W +: FLIT_W]),
      .pop       (pop[p]),
      .full      (full[p]),
      .empty     (empty[p]),
      .head      (head[p])
    );
  end

  assign in_ready = ~full;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req  = '0;
    drop = '0;
    rt   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      rt = xy_route(32'(head[i][FLIT_W-1 -: XW]), 32'(head[i][DATA_W +: YW]),
                    32'(router_x), 32'(router_y), MESH_X, MESH_Y);
      if (!empty[i]) begin
        if (rt.drop) drop[i] = 1'b1;
        else         req[rt.port][i] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [PORT_W-1:0]  rr_q, rr_d, win;
    logic               out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]  out_data_q, out_data_d;
    logic [N_PORTS-1:0] gnt;
    logic               found, load;
    logic [3:0]         idx;

    always_comb begin
      gnt         = '0;
      found       = 1'b0;
      win         = '0;
      idx         = '0;
      load        = ~out_valid_q | out_ready[o];
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rr_d        = rr_q;
      // Scan cyclically starting at the round-robin pointer.
      for (int k = 0; k < N_PORTS; k++) begin
        idx = {1'b0, rr_q} + 4'(k);
        if (idx >= 4'(N_PORTS)) idx = idx - 4'(N_PORTS);
        if (!found && req[o][idx[PORT_W-1:0]]) begin
          gnt[idx[PORT_W-1:0]] = 1'b1;
          win                  = idx[PORT_W-1:0];
          found                = 1'b1;
        end
      end
      if (load) begin
        out_valid_d = found;
        if (found) begin
          out_data_d = head[win];
          rr_d       = rr_next(win);
        end
      end
    end

    assign gnt_eff[o] = gnt & {N_PORTS{load}};
    assign out_valid[o]                    = out_valid_q;
    assign out_data[o*FLIT_W +: FLIT_W]    = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_q        <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        rr_q        <= rr_d;
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end
  end

  always_comb begin
    pop = drop;
    for (int o = 0; o < N_PORTS; o++) pop = pop | gnt_eff[o];
  end

  always_comb begin
    drop_sum   = {3'b0, drop_cnt_q} + 19'($countones(drop));
    drop_cnt_d = (drop_sum > 19'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed and random checks for noc_mesh_router: reset, XY routing, arbitration, backpressure, drops.
module tb_noc_mesh_router;

  localparam int FW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    rx, ry, erx, ery;
  logic [5*FW-1:0] in_data, out_data, e_in_data, e_out_data;
  logic [4:0]    in_valid, in_ready, out_valid, out_ready;
  logic [4:0]    e_in_valid, e_in_ready, e_out_valid, e_out_ready;
  logic [15:0]   drop_cnt, e_drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] sbq [5][5][$];

  always #5 clk = ~clk;

  noc_mesh_router #(.DATA_W(16), .MESH_X(8), .MESH_Y(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .router_x(rx), .router_y(ry),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  // 6x6 mesh instance at (5,0): out-of-mesh destinations are reachable here.
  noc_mesh_router #(.DATA_W(16), .MESH_X(6), .MESH_Y(6), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .router_x(erx), .router_y(ery),
    .in_data(e_in_data), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .out_data(e_out_data), .out_valid(e_out_valid), .out_ready(e_out_ready), .drop_cnt(e_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int x, input int y, input int pl);
    return {3'(x), 3'(y), 16'(pl)};
  endfunction

  // Reference XY route for router (3,3) in the 8x8 mesh.
  function automatic int ref_route(input logic [FW-1:0] f);
    int x, y;
    x = int'(f[21:19]);
    y = int'(f[18:16]);
    if (x > 3) return 2;
    if (x < 3) return 4;
    if (y > 3) return 1;
    if (y < 3) return 3;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic [FW-1:0] f);
    in_data[p*FW +: FW] = f;
    in_valid[p] = 1'b1;
  endtask

  // Expects exp_q contents on output p in order; out_ready[p] must be high.
  task automatic collect(input string tag, input int p, input int n, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_valid[p]) begin
        check($sformatf("%s_%0d", tag, got), 32'(out_data[p*FW +: FW]), 32'(exp_q.pop_front()));
        got++;
      end
      step();
    end
    check({tag, "_count"}, got, n);
    check({tag, "_nodup"}, 32'(out_valid[p]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    int src;
    int seq [5];
    int left;

    rst_n = 1'b0;
    rx = 3'd3; ry = 3'd3; erx = 3'd5; ery = 3'd0;
    in_data = '0; in_valid = '0; out_ready = '0;
    e_in_data = '0; e_in_valid = '0; e_out_ready = '1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data[2*FW +: FW]), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'h1F);

    // Reset asserted mid-traffic
    for (int i = 0; i < 3; i++) begin
      drive(0, mk(5, 3, 16'h100 + i));
      step();
    end
    check("mid_out_valid_pre", 32'(out_valid[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_out_data", 32'(out_data[2*FW +: FW]), 0);
    check("mid_drop", 32'(drop_cnt), 0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = '1;
    step();
    check("mid_in_ready", 32'(in_ready), 32'h1F);
    check("mid_no_stale", 32'(out_valid), 0);

    // Routing from (3,3): dst(5,1) exits EAST one edge after acceptance
    drive(0, mk(5, 1, 16'h0051));
    step();
    in_valid = '0;
    check("east_early", 32'(out_valid[2]), 0);
    step();
    check("east_valid", 32'(out_valid), 32'h04);
    check("east_data", 32'(out_data[2*FW +: FW]), 32'(mk(5, 1, 16'h0051)));
    step();
    check("east_drain", 32'(out_valid[2]), 0);

    drive(0, mk(3, 3, 16'h0033));
    step();
    in_valid = '0;
    step();
    check("loop_valid", 32'(out_valid), 32'h01);
    check("loop_data", 32'(out_data[0 +: FW]), 32'(mk(3, 3, 16'h0033)));
    step();

    // Contention on LOCAL: N, S, W arrive together
    drive(1, mk(3, 3, 16'h0A01));
    drive(3, mk(3, 3, 16'h0A03));
    drive(4, mk(3, 3, 16'h0A04));
    exp_q = '{mk(3, 3, 16'h0A01), mk(3, 3, 16'h0A03), mk(3, 3, 16'h0A04)};
    step();
    in_valid = '0;
    collect("rr1", 0, 3, 8);
    // Pointer now sits at LOCAL (W+1), so LOCAL wins over WEST
    drive(4, mk(3, 3, 16'h0B04));
    drive(0, mk(3, 3, 16'h0B00));
    exp_q = '{mk(3, 3, 16'h0B00), mk(3, 3, 16'h0B04)};
    step();
    in_valid = '0;
    collect("rr2", 0, 2, 8);

    // Backpressure on EAST with six flits from WEST
    out_ready[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4, mk(6, 3, 16'h0C00 + i));
      step();
    end
    check("bp_full", 32'(in_ready[4]), 0);
    check("bp_hold_valid", 32'(out_valid[2]), 1);
    check("bp_hold_data", 32'(out_data[2*FW +: FW]), 32'(mk(6, 3, 16'h0C00)));
    drive(4, mk(6, 3, 16'h0C05));
    step();
    step();
    check("bp_stall", 32'(in_ready[4]), 0);
    check("bp_stable", 32'(out_data[2*FW +: FW]), 32'(mk(6, 3, 16'h0C00)));
    in_valid = '0;
    out_ready[2] = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(6, 3, 16'h0C00 + i));
    collect("bp", 2, 5, 12);

    // Drops on the 6x6 router at (5,0)
    e_in_data[0 +: FW] = mk(5, 0, 16'h0E00);
    e_in_valid[0] = 1'b1;
    step();
    e_in_valid = '0;
    step();
    check("e_loop_valid", 32'(e_out_valid), 32'h01);
    check("e_loop_data", 32'(e_out_data[0 +: FW]), 32'(mk(5, 0, 16'h0E00)));
    step();
    e_in_data[0 +: FW] = mk(7, 1, 16'h0E01);
    e_in_valid[0] = 1'b1;
    step();
    e_in_valid = '0;
    step();
    check("drop_cnt1", 32'(e_drop_cnt), 1);
    check("drop_no_out", 32'(e_out_valid), 0);
    step();
    check("drop_no_out2", 32'(e_out_valid), 0);
    force dut_e.drop_cnt_q = 16'hFFFF;
    step();
    release dut_e.drop_cnt_q;
    e_in_data[1*FW +: FW] = mk(6, 2, 16'h0E02);
    e_in_valid[1] = 1'b1;
    step();
    e_in_valid = '0;
    step();
    check("drop_sat", 32'(e_drop_cnt), 32'hFFFF);
    check("drop_sat_no_out", 32'(e_out_valid), 0);

    // Random XY traffic with a per-input/per-output scoreboard
    for (int p = 0; p < 5; p++) seq[p] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 5; p++) begin
        in_valid[p] = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data[p*FW +: FW] = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                               3'(p), 13'(seq[p])};
      end
      out_ready = (cyc < 300) ? 5'($urandom) : 5'h1F;
      #1;
      for (int p = 0; p < 5; p++) begin
        if (in_valid[p] && in_ready[p]) begin
          f = in_data[p*FW +: FW];
          sbq[p][ref_route(f)].push_back(f);
          seq[p]++;
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          f = out_data[o*FW +: FW];
          src = int'(f[15:13]);
          if (src > 4) check("rnd_src", 32'(src), 0);
          else if (sbq[src][o].size() == 0) check("rnd_unexpected", 32'(f), 0);
          else check($sformatf("rnd_o%0d", o), 32'(f), 32'(sbq[src][o].pop_front()));
        end
      end
      step();
    end
    left = 0;
    for (int p = 0; p < 5; p++)
      for (int o = 0; o < 5; o++) left += sbq[p][o].size();
    check("rnd_undelivered", 32'(left), 0);
    check("rnd_no_drop", 32'(drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
